// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, 3-5 cycles per instruction, stalls on mem_ready.
// Optional ILLEGAL_OP_TRAP_EN: unknown opcodes go to TRAP (PCSource=11) instead of falling back to FETCH.
module multicycle_control_unit #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemToReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               instr_done,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_R_EXEC   = 4'd3,
    S_R_WB     = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_I_EXEC   = 4'd11,
    S_I_WB     = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_ANDI = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'b001010);

  state_t          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RST;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_RST:      state_d = S_FETCH;
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        // Later states decode op_q so the IR may change once DECODE is past.
        op_d = op;
        case (op)
          OP_R:                               state_d = S_R_EXEC;
          OP_LW, OP_SW:                       state_d = S_MEM_ADDR;
          OP_BEQ:                             state_d = S_BRANCH;
          OP_J:                               state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_d = S_I_EXEC;
`ifdef ILLEGAL_OP_TRAP_EN
          default:                            state_d = S_TRAP;
`else
          default:                            state_d = S_FETCH;
`endif
        endcase
      end
      S_R_EXEC:   state_d = S_R_WB;
      S_MEM_ADDR: state_d = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_I_EXEC:   state_d = S_I_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = '0;
    instr_done  = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE:   ALUSrcB = 2'b11;
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_W'(3'b010);
      end
      S_R_WB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        MemToReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_W'(3'b001);
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      S_I_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (op_q)
          OP_ANDI: ALUOp = ALUOP_W'(3'b011);
          OP_ORI:  ALUOp = ALUOP_W'(3'b100);
          OP_SLTI: ALUOp = ALUOP_W'(3'b101);
          default: ALUOp = ALUOP_W'(3'b000);
        endcase
      end
      S_I_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      S_TRAP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b11;
        instr_done = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-cycle stimulus/expectation scoreboard, one task per scenario.
module tb_multicycle_control_unit;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemToReg, RegDst, RegWrite, ALUSrcA, instr_done;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] state;
  logic [17:0] outs;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .instr_done(instr_done), .state(state)
  );

  always #5 clk = ~clk;

  assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
                 RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, instr_done};

  function automatic logic [17:0] mk(input logic pcw, pcwc, iord, mrd, mwr, irw, mtr,
                                     rdst, rw, asa, input logic [1:0] asb, pcs,
                                     input logic [2:0] aop, input logic done);
    return {pcw, pcwc, iord, mrd, mwr, irw, mtr, rdst, rw, asa, asb, pcs, aop, done};
  endfunction

  localparam logic [3:0] ST_RST = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2, ST_R_EXEC = 4'd3,
                         ST_R_WB = 4'd4, ST_MEM_ADDR = 4'd5, ST_MEM_RD = 4'd6, ST_MEM_WB = 4'd7,
                         ST_MEM_WR = 4'd8, ST_BRANCH = 4'd9, ST_JUMP = 4'd10, ST_I_EXEC = 4'd11,
                         ST_I_WB = 4'd12, ST_TRAP = 4'd13;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000,
                         OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_SLTI = 6'b001010,
                         OP_BAD = 6'b111111;

  //                                  pcw pcwc iord mrd mwr irw mtr rdst rw asa asb    pcs    aluop   done
  localparam logic [17:0] O_ZERO    = mk(0, 0,   0,   0,  0,  0,  0,  0,   0, 0, 2'b00, 2'b00, 3'b000, 0);
  localparam logic [17:0] O_FETCH   = mk(1, 0,   0,   1,  0,  1,  0,  0,   0, 0, 2'b01, 2'b00, 3'b000, 0);
  localparam logic [17:0] O_FSTALL  = mk(0, 0,   0,   1,  0,  0,  0,  0,   0, 0, 2'b01, 2'b00, 3'b000, 0);
  localparam logic [17:0] O_DECODE  = mk(0, 0,   0,   0,  0,  0,  0,  0,   0, 0, 2'b11, 2'b00, 3'b000, 0);
  localparam logic [17:0] O_R_EXEC  = mk(0, 0,   0,   0,  0,  0,  0,  0,   0, 1, 2'b00, 2'b00, 3'b010, 0);
  localparam logic [17:0] O_R_WB    = mk(0, 0,   0,   0,  0,  0,  0,  1,   1, 0, 2'b00, 2'b00, 3'b000, 1);
  localparam logic [17:0] O_MADDR   = mk(0, 0,   0,   0,  0,  0,  0,  0,   0, 1, 2'b10, 2'b00, 3'b000, 0);
  localparam logic [17:0] O_MEM_RD  = mk(0, 0,   1,   1,  0,  0,  0,  0,   0, 0, 2'b00, 2'b00, 3'b000, 0);
  localparam logic [17:0] O_MEM_WB  = mk(0, 0,   0,   0,  0,  0,  1,  0,   1, 0, 2'b00, 2'b00, 3'b000, 1);
  localparam logic [17:0] O_WR_STL  = mk(0, 0,   1,   0,  1,  0,  0,  0,   0, 0, 2'b00, 2'b00, 3'b000, 0);
  localparam logic [17:0] O_WR_DONE = mk(0, 0,   1,   0,  1,  0,  0,  0,   0, 0, 2'b00, 2'b00, 3'b000, 1);
  localparam logic [17:0] O_BRANCH  = mk(0, 1,   0,   0,  0,  0,  0,  0,   0, 1, 2'b00, 2'b01, 3'b001, 1);
  localparam logic [17:0] O_JUMP    = mk(1, 0,   0,   0,  0,  0,  0,  0,   0, 0, 2'b00, 2'b10, 3'b000, 1);
  localparam logic [17:0] O_I_WB    = mk(0, 0,   0,   0,  0,  0,  0,  0,   1, 0, 2'b00, 2'b00, 3'b000, 1);
  localparam logic [17:0] O_TRAP    = mk(1, 0,   0,   0,  0,  0,  0,  0,   0, 0, 2'b00, 2'b11, 3'b000, 1);

  function automatic logic [17:0] o_i_exec(input logic [2:0] aop);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, aop, 0);
  endfunction

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [17:0] outs;
  } step_t;

  step_t sb[$];

  // Queue one cycle: the inputs to apply and the state/outputs required during that cycle.
  task automatic plan(input logic r, input logic [5:0] o, input logic m,
                      input logic [3:0] s, input logic [17:0] v);
    step_t e;
    e.rst = r; e.op = o; e.mr = m; e.st = s; e.outs = v;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    step_t e;
    plan(0, OP_R,  0, ST_RST,      O_ZERO);
    plan(1, OP_LW, 1, ST_RST,      O_ZERO);
    plan(1, OP_LW, 1, ST_FETCH,    O_FETCH);
    plan(1, OP_LW, 1, ST_DECODE,   O_DECODE);
    plan(1, OP_R,  0, ST_MEM_ADDR, O_MADDR);
    plan(1, OP_R,  0, ST_MEM_RD,   O_MEM_RD);
    plan(0, OP_R,  1, ST_MEM_RD,   O_MEM_RD);
    plan(0, OP_R,  1, ST_RST,      O_ZERO);
    plan(1, OP_R,  1, ST_RST,      O_ZERO);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk);
      rst_n = e.rst; op = e.op; mem_ready = e.mr;
      #1;
      cyc++;
      checks++;
      if (state !== e.st) begin
        errors++;
        $display("FAIL reset cyc%0d state got %0d want %0d", cyc, state, e.st);
      end
      checks++;
      if (outs !== e.outs) begin
        errors++;
        $display("FAIL reset cyc%0d outs got %b want %b", cyc, outs, e.outs);
      end
    end
  endtask

  task automatic test_r_type();
    step_t e;
    plan(1, OP_R, 1, ST_FETCH,  O_FETCH);
    plan(1, OP_R, 1, ST_DECODE, O_DECODE);
    plan(1, OP_R, 0, ST_R_EXEC, O_R_EXEC);
    plan(1, OP_R, 0, ST_R_WB,   O_R_WB);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk);
      rst_n = e.rst; op = e.op; mem_ready = e.mr;
      #1;
      cyc++;
      checks++;
      if (state !== e.st) begin
        errors++;
        $display("FAIL r_type cyc%0d state got %0d want %0d", cyc, state, e.st);
      end
      checks++;
      if (outs !== e.outs) begin
        errors++;
        $display("FAIL r_type cyc%0d outs got %b want %b", cyc, outs, e.outs);
      end
    end
  endtask

  task automatic test_lw_stall();
    step_t e;
    plan(1, OP_LW, 1, ST_FETCH,    O_FETCH);
    plan(1, OP_LW, 1, ST_DECODE,   O_DECODE);
    plan(1, OP_LW, 1, ST_MEM_ADDR, O_MADDR);
    for (int i = 0; i < 3; i++) plan(1, OP_LW, 0, ST_MEM_RD, O_MEM_RD);
    plan(1, OP_LW, 1, ST_MEM_RD,   O_MEM_RD);
    plan(1, OP_LW, 1, ST_MEM_WB,   O_MEM_WB);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk);
      rst_n = e.rst; op = e.op; mem_ready = e.mr;
      #1;
      cyc++;
      checks++;
      if (state !== e.st) begin
        errors++;
        $display("FAIL lw_stall cyc%0d state got %0d want %0d", cyc, state, e.st);
      end
      checks++;
      if (outs !== e.outs) begin
        errors++;
        $display("FAIL lw_stall cyc%0d outs got %b want %b", cyc, outs, e.outs);
      end
    end
  endtask

  task automatic test_sw_beq_j();
    step_t e;
    plan(1, OP_SW,  1, ST_FETCH,    O_FETCH);
    plan(1, OP_SW,  1, ST_DECODE,   O_DECODE);
    plan(1, OP_SW,  1, ST_MEM_ADDR, O_MADDR);
    plan(1, OP_SW,  0, ST_MEM_WR,   O_WR_STL);
    plan(1, OP_SW,  1, ST_MEM_WR,   O_WR_DONE);
    plan(1, OP_BEQ, 0, ST_FETCH,    O_FSTALL);
    plan(1, OP_BEQ, 1, ST_FETCH,    O_FETCH);
    plan(1, OP_BEQ, 0, ST_DECODE,   O_DECODE);
    plan(1, OP_BEQ, 0, ST_BRANCH,   O_BRANCH);
    plan(1, OP_J,   1, ST_FETCH,    O_FETCH);
    plan(1, OP_J,   1, ST_DECODE,   O_DECODE);
    plan(1, OP_J,   1, ST_JUMP,     O_JUMP);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk);
      rst_n = e.rst; op = e.op; mem_ready = e.mr;
      #1;
      cyc++;
      checks++;
      if (state !== e.st) begin
        errors++;
        $display("FAIL sw_beq_j cyc%0d state got %0d want %0d", cyc, state, e.st);
      end
      checks++;
      if (outs !== e.outs) begin
        errors++;
        $display("FAIL sw_beq_j cyc%0d outs got %b want %b", cyc, outs, e.outs);
      end
    end
  endtask

  task automatic test_i_alu();
    step_t e;
    // op changes after DECODE; ALUOp must still reflect ori.
    plan(1, OP_ORI, 1, ST_FETCH,  O_FETCH);
    plan(1, OP_ORI, 1, ST_DECODE, O_DECODE);
    plan(1, OP_R,   1, ST_I_EXEC, o_i_exec(3'b100));
    plan(1, OP_LW,  1, ST_I_WB,   O_I_WB);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk);
      rst_n = e.rst; op = e.op; mem_ready = e.mr;
      #1;
      cyc++;
      checks++;
      if (state !== e.st) begin
        errors++;
        $display("FAIL i_alu cyc%0d state got %0d want %0d", cyc, state, e.st);
      end
      checks++;
      if (outs !== e.outs) begin
        errors++;
        $display("FAIL i_alu cyc%0d outs got %b want %b", cyc, outs, e.outs);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t e;
    logic [5:0] ops [3];
    logic [2:0] aops[3];
    ops[0] = OP_ADDI; aops[0] = 3'b000;
    ops[1] = OP_ANDI; aops[1] = 3'b011;
    ops[2] = OP_SLTI; aops[2] = 3'b101;
    for (int i = 0; i < 3; i++) begin
      plan(1, ops[i], 1, ST_FETCH,  O_FETCH);
      plan(1, ops[i], 1, ST_DECODE, O_DECODE);
      plan(1, OP_ORI, 0, ST_I_EXEC, o_i_exec(aops[i]));
      plan(1, OP_SW,  0, ST_I_WB,   O_I_WB);
    end
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk);
      rst_n = e.rst; op = e.op; mem_ready = e.mr;
      #1;
      cyc++;
      checks++;
      if (state !== e.st) begin
        errors++;
        $display("FAIL back_to_back cyc%0d state got %0d want %0d", cyc, state, e.st);
      end
      checks++;
      if (outs !== e.outs) begin
        errors++;
        $display("FAIL back_to_back cyc%0d outs got %b want %b", cyc, outs, e.outs);
      end
    end
  endtask

  task automatic test_illegal_op();
    step_t e;
    plan(1, OP_BAD, 1, ST_FETCH,  O_FETCH);
    plan(1, OP_BAD, 1, ST_DECODE, O_DECODE);
`ifdef ILLEGAL_OP_TRAP_EN
    plan(1, OP_R,   1, ST_TRAP,   O_TRAP);
`endif
    plan(1, OP_R,   0, ST_FETCH,  O_FSTALL);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk);
      rst_n = e.rst; op = e.op; mem_ready = e.mr;
      #1;
      cyc++;
      checks++;
      if (state !== e.st) begin
        errors++;
        $display("FAIL illegal_op cyc%0d state got %0d want %0d", cyc, state, e.st);
      end
      checks++;
      if (outs !== e.outs) begin
        errors++;
        $display("FAIL illegal_op cyc%0d outs got %b want %b", cyc, outs, e.outs);
      end
    end
  endtask

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    op        = OP_R;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_r_type();
    test_lw_stall();
    test_sw_beq_j();
    test_i_alu();
    test_back_to_back();
    test_illegal_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
